// File: rtl/cordic_pkg.sv
// Shared constants for the rotation-mode CORDIC pipeline: arctangent table,
// guard-bit count and the 1/K gain constant.
package cordic_pkg;

  localparam int          GUARD_BITS = 2;
  localparam int          MAX_STAGES = 16;
  localparam int          ANGLE_W    = 16;
  localparam logic [15:0] K_INV_Q15  = 16'h4DBA;

  // atan(2^-i) in binary angle units where 0x10000 is one full turn
  function automatic logic [ANGLE_W-1:0] atan_lut(input int idx);
    logic [ANGLE_W-1:0] r;
    case (idx)
      0:       r = 16'h2000;
      1:       r = 16'h12E4;
      2:       r = 16'h09FB;
      3:       r = 16'h0511;
      4:       r = 16'h028B;
      5:       r = 16'h0146;
      6:       r = 16'h00A3;
      7:       r = 16'h0051;
      8:       r = 16'h0029;
      9:       r = 16'h0014;
      10:      r = 16'h000A;
      11:      r = 16'h0005;
      12:      r = 16'h0003;
      13:      r = 16'h0001;
      14:      r = 16'h0001;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation by +/-atan(2^-SHIFT), with its valid bit.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int W     = 18,
  parameter int Z_W   = 16,
  parameter int SHIFT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                valid_i,
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  input  logic [Z_W-1:0]      z_i,
  output logic                valid_o,
  output logic signed [W-1:0] x_o,
  output logic signed [W-1:0] y_o,
  output logic [Z_W-1:0]      z_o
);

  localparam logic [Z_W-1:0] ATAN = Z_W'(atan_lut(SHIFT));

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;
  logic                rot_pos;
  logic signed [W-1:0] x_d, y_d, x_q, y_q;
  logic [Z_W-1:0]      z_d, z_q;
  logic                valid_q;

  assign x_sh    = x_i >>> SHIFT;
  assign y_sh    = y_i >>> SHIFT;
  assign rot_pos = ~z_i[Z_W-1];

  always_comb begin
    x_d = x_i + y_sh;
    y_d = y_i - x_sh;
    z_d = z_i + ATAN;
    if (rot_pos) begin
      x_d = x_i - y_sh;
      y_d = y_i + x_sh;
      z_d = z_i - ATAN;
    end
  end

  // Data loads on every enabled clock; invalid slots simply carry junk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else if (en) begin
      valid_q <= valid_i;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign z_o     = z_q;

endmodule

// File: rtl/cordic_rot_pipe.sv
// Pipelined rotation-mode CORDIC: registered quadrant pre-rotation followed by
// STAGES registered micro-rotations. Output gain K is left uncompensated.
module cordic_rot_pipe
  import cordic_pkg::*;
#(
  parameter int XY_W   = 16,
  parameter int Z_W    = 16,
  parameter int STAGES = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [XY_W-1:0]   x_in,
  input  logic [XY_W-1:0]   y_in,
  input  logic [Z_W-1:0]    z_in,
  output logic              out_valid,
  output logic [XY_W+1:0]   x_out,
  output logic [XY_W+1:0]   y_out,
  output logic [Z_W-1:0]    z_res
);

  localparam int W = XY_W + GUARD_BITS;
  localparam logic [Z_W-1:0] QUARTER = Z_W'(1) << (Z_W - 2);

  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("cordic_rot_pipe: STAGES must be in 1..16");
  end
  if (Z_W != ANGLE_W) begin : g_bad_zw
    $error("cordic_rot_pipe: arctangent table is defined for 16-bit angles only");
  end

  logic signed [W-1:0] x_ext, y_ext;
  logic signed [W-1:0] pre_x_d, pre_y_d, pre_x_q, pre_y_q;
  logic [Z_W-1:0]      pre_z_d, pre_z_q;
  logic                pre_valid_q;

  assign x_ext = {{GUARD_BITS{x_in[XY_W-1]}}, x_in};
  assign y_ext = {{GUARD_BITS{y_in[XY_W-1]}}, y_in};

  // Fold angles beyond +/-pi/2 by a quarter turn so the iterations can converge.
  always_comb begin
    pre_x_d = x_ext;
    pre_y_d = y_ext;
    pre_z_d = z_in;
    case (z_in[Z_W-1 -: 2])
      2'b01: begin
        pre_x_d = -y_ext;
        pre_y_d = x_ext;
        pre_z_d = z_in - QUARTER;
      end
      2'b10: begin
        pre_x_d = y_ext;
        pre_y_d = -x_ext;
        pre_z_d = z_in + QUARTER;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_valid_q <= 1'b0;
      pre_x_q     <= '0;
      pre_y_q     <= '0;
      pre_z_q     <= '0;
    end else if (en) begin
      pre_valid_q <= in_valid;
      pre_x_q     <= pre_x_d;
      pre_y_q     <= pre_y_d;
      pre_z_q     <= pre_z_d;
    end
  end

  logic                valid_chain [0:STAGES];
  logic signed [W-1:0] x_chain     [0:STAGES];
  logic signed [W-1:0] y_chain     [0:STAGES];
  logic [Z_W-1:0]      z_chain     [0:STAGES];

  assign valid_chain[0] = pre_valid_q;
  assign x_chain[0]     = pre_x_q;
  assign y_chain[0]     = pre_y_q;
  assign z_chain[0]     = pre_z_q;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    cordic_stage #(
      .W     (W),
      .Z_W   (Z_W),
      .SHIFT (gi)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .valid_i (valid_chain[gi]),
      .x_i     (x_chain[gi]),
      .y_i     (y_chain[gi]),
      .z_i     (z_chain[gi]),
      .valid_o (valid_chain[gi+1]),
      .x_o     (x_chain[gi+1]),
      .y_o     (y_chain[gi+1]),
      .z_o     (z_chain[gi+1])
    );
  end

  assign out_valid = valid_chain[STAGES];
  assign x_out     = x_chain[STAGES];
  assign y_out     = y_chain[STAGES];
  assign z_res     = z_chain[STAGES];

endmodule
